fpga_spi_cmd_rx: RTL and testbench

- Synchronous replacement for the ad-hoc SPI command receiver at the front of the HF top level.
- Oversamples ARM SPI pins (spck, mosi, ncs) in the ck_1356meg domain, assembles 16-bit command frames, validates bit count, and decodes them into conf_word and trace_enable.
- Shifts a status/readback word out on miso during each frame.
- Directly upstream of the major-mode muxes and mode modules; removes the posedge-ncs/posedge-spck clocking from the top level.

---
 rtl/fpga_spi_cmd_rx_pkg.sv | 23 ++
 rtl/fpga_spi_cmd_rx_if.sv | 21 ++
 rtl/fpga_spi_cmd_rx_spi_pin_sync.sv | 28 ++
 rtl/fpga_spi_cmd_rx.sv | 154 +++++++++++++++
 tb/tb_fpga_spi_cmd_rx.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fpga_spi_cmd_rx_pkg.sv
// rtl/fpga_spi_cmd_rx_pkg.sv - shared opcodes, reset constants and FSM encoding for the SPI command receiver
package fpga_spi_cmd_rx_pkg;

  localparam logic [3:0] FPGA_CMD_SET_CONFREG  = 4'h1;
  localparam logic [3:0] FPGA_CMD_TRACE_ENABLE = 4'h2;

  // Major mode 7 (OFF) so the RF front end stays quiet until the ARM configures it
  localparam logic [8:0] CONF_RESET_VAL = 9'h1C0;
  localparam logic [3:0] STATUS_NIBBLE  = 4'hA;

  localparam int BIT_CNT_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } rx_state_e;

  function automatic logic [BIT_CNT_W-1:0] sat_inc_bitcnt(input logic [BIT_CNT_W-1:0] v);
    return (v == {BIT_CNT_W{1'b1}}) ? v : v + BIT_CNT_W'(1);
  endfunction

endpackage

// File: rtl/fpga_spi_cmd_rx_if.sv
// rtl/fpga_spi_cmd_rx_if.sv - ARM SPI pin bundle between the ARM-side master and the FPGA receiver
interface fpga_spi_cmd_rx_if;
  logic spck;
  logic mosi;
  logic ncs;
  logic miso;

  modport master (
    output spck,
    output mosi,
    output ncs,
    input  miso
  );

  modport slave (
    input  spck,
    input  mosi,
    input  ncs,
    output miso
  );
endinterface

// File: rtl/fpga_spi_cmd_rx_spi_pin_sync.sv
// rtl/fpga_spi_cmd_rx_spi_pin_sync.sv - two-flop synchroniser plus edge stage yielding one-cycle rise/fall events
module fpga_spi_cmd_rx_spi_pin_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], pin_i};
    end
  end

  // sync_q[1] is the first metastability-safe stage; sync_q[2] is its one-cycle-old copy
  assign sync_o = sync_q[1];
  assign rise_o = sync_q[1] & ~sync_q[2];
  assign fall_o = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/fpga_spi_cmd_rx.sv
// rtl/fpga_spi_cmd_rx.sv - oversampled SPI command receiver: frames ARM commands into conf_word/trace_enable
module fpga_spi_cmd_rx
  import fpga_spi_cmd_rx_pkg::*;
#(
  parameter int FRAME_BITS = 16,
  parameter int CONF_W     = 9,
  parameter int ERRCNT_W   = 8
) (
  input  logic                ck_1356meg,
  input  logic                nreset,
  fpga_spi_cmd_rx_if.slave    spi,
  output logic [CONF_W-1:0]   conf_word,
  output logic                trace_enable,
  output logic                cmd_strobe,
  output logic                frame_err,
  output logic [ERRCNT_W-1:0] err_cnt,
  input  logic                clr_err
);

  logic spck_rise, spck_fall, spck_unused_sync;
  logic mosi_sync, mosi_unused_rise, mosi_unused_fall;
  logic ncs_rise, ncs_fall, ncs_unused_sync;

  fpga_spi_cmd_rx_spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_spck (
    .clk    (ck_1356meg),
    .rst_n  (nreset),
    .pin_i  (spi.spck),
    .sync_o (spck_unused_sync),
    .rise_o (spck_rise),
    .fall_o (spck_fall)
  );

  fpga_spi_cmd_rx_spi_pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk    (ck_1356meg),
    .rst_n  (nreset),
    .pin_i  (spi.mosi),
    .sync_o (mosi_sync),
    .rise_o (mosi_unused_rise),
    .fall_o (mosi_unused_fall)
  );

  fpga_spi_cmd_rx_spi_pin_sync #(.RESET_VAL(1'b1)) u_sync_ncs (
    .clk    (ck_1356meg),
    .rst_n  (nreset),
    .pin_i  (spi.ncs),
    .sync_o (ncs_unused_sync),
    .rise_o (ncs_rise),
    .fall_o (ncs_fall)
  );

  rx_state_e               state_q;
  logic [FRAME_BITS-1:0]   shift_reg_q;
  logic [FRAME_BITS-1:0]   tx_reg_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic                    miso_q;
  logic [CONF_W-1:0]       conf_word_q;
  logic                    trace_enable_q;
  logic                    cmd_strobe_q;
  logic                    frame_err_q, frame_err_d;
  logic [ERRCNT_W-1:0]     err_cnt_q, err_cnt_d;

  logic [FRAME_BITS-1:0]   tx_load;
  logic [3:0]              opcode;
  logic                    frame_ok;
  logic                    unused_shift_bits;

  assign tx_load  = {STATUS_NIBBLE, {(FRAME_BITS-4-CONF_W){1'b0}}, conf_word_q};
  assign opcode   = shift_reg_q[FRAME_BITS-1 -: 4];
  assign frame_ok = (bit_cnt_q == BIT_CNT_W'(FRAME_BITS));
  assign unused_shift_bits = ^shift_reg_q[FRAME_BITS-5:CONF_W];

  // Clearing wins over a bad frame committing in the same cycle
  always_comb begin
    frame_err_d = frame_err_q;
    err_cnt_d   = err_cnt_q;
    if (clr_err) begin
      frame_err_d = 1'b0;
      err_cnt_d   = '0;
    end else if (state_q == ST_COMMIT && !frame_ok) begin
      frame_err_d = 1'b1;
      if (err_cnt_q != {ERRCNT_W{1'b1}}) begin
        err_cnt_d = err_cnt_q + ERRCNT_W'(1);
      end
    end
  end

  always_ff @(posedge ck_1356meg or negedge nreset) begin
    if (!nreset) begin
      state_q        <= ST_IDLE;
      shift_reg_q    <= '0;
      tx_reg_q       <= '0;
      bit_cnt_q      <= '0;
      miso_q         <= 1'b0;
      conf_word_q    <= CONF_W'(CONF_RESET_VAL);
      trace_enable_q <= 1'b0;
      cmd_strobe_q   <= 1'b0;
      frame_err_q    <= 1'b0;
      err_cnt_q      <= '0;
    end else begin
      cmd_strobe_q <= 1'b0;
      frame_err_q  <= frame_err_d;
      err_cnt_q    <= err_cnt_d;
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall) begin
            state_q     <= ST_SHIFT;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            tx_reg_q    <= tx_load;
            miso_q      <= tx_load[FRAME_BITS-1];
          end
        end
        ST_SHIFT: begin
          // Frame end takes precedence: a clock edge coincident with ncs rising is not data
          if (ncs_rise) begin
            state_q <= ST_COMMIT;
          end else begin
            if (spck_rise) begin
              shift_reg_q <= {shift_reg_q[FRAME_BITS-2:0], mosi_sync};
              bit_cnt_q   <= sat_inc_bitcnt(bit_cnt_q);
            end
            if (spck_fall) begin
              tx_reg_q <= {tx_reg_q[FRAME_BITS-2:0], 1'b0};
              miso_q   <= tx_reg_q[FRAME_BITS-2];
            end
          end
        end
        ST_COMMIT: begin
          state_q <= ST_IDLE;
          miso_q  <= 1'b0;
          if (frame_ok) begin
            cmd_strobe_q <= 1'b1;
            if (opcode == FPGA_CMD_SET_CONFREG) begin
              conf_word_q <= shift_reg_q[CONF_W-1:0];
            end else if (opcode == FPGA_CMD_TRACE_ENABLE) begin
              trace_enable_q <= shift_reg_q[0];
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign spi.miso     = miso_q;
  assign conf_word    = conf_word_q;
  assign trace_enable = trace_enable_q;
  assign cmd_strobe   = cmd_strobe_q;
  assign frame_err    = frame_err_q;
  assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_fpga_spi_cmd_rx.sv
// tb/tb_fpga_spi_cmd_rx.sv - scoreboard bench for the SPI command receiver
module tb_fpga_spi_cmd_rx;
  import fpga_spi_cmd_rx_pkg::*;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       clr_err = 1'b0;
  logic [8:0] conf_word;
  logic       trace_enable, cmd_strobe, frame_err;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  fpga_spi_cmd_rx_if spi();

  fpga_spi_cmd_rx dut (
    .ck_1356meg   (clk),
    .nreset       (nreset),
    .spi          (spi),
    .conf_word    (conf_word),
    .trace_enable (trace_enable),
    .cmd_strobe   (cmd_strobe),
    .frame_err    (frame_err),
    .err_cnt      (err_cnt),
    .clr_err      (clr_err)
  );

  typedef struct packed {
    logic [8:0] conf;
    logic       trace;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [8:0] conf_m = 9'h1C0;
  logic       trace_m = 1'b0;
  logic [31:0] rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (cmd_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_strobe", {31'b0, cmd_strobe}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("strobe_conf", {23'b0, conf_word}, {23'b0, e.conf});
        chk("strobe_trace", {31'b0, trace_enable}, {31'b0, e.trace});
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [31:0] data, input int nbits, output logic [31:0] r);
    r = '0;
    for (int i = nbits - 1; i >= 0; i--) begin
      spi.mosi = data[i];
      cyc(4);
      spi.spck = 1'b1;
      r = {r[30:0], spi.miso};
      cyc(4);
      spi.spck = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] data, input int nbits, output logic [31:0] r);
    spi.ncs = 1'b0;
    cyc(4);
    send_bits(data, nbits, r);
    cyc(4);
    spi.ncs = 1'b1;
  endtask

  task automatic model(input logic [15:0] w);
    if (w[15:12] == 4'h1) conf_m = w[8:0];
    else if (w[15:12] == 4'h2) trace_m = w[0];
    exp_q.push_back({conf_m, trace_m});
  endtask

  task automatic full(input logic [15:0] w);
    logic [31:0] r;
    logic [15:0] exp_rd;
    exp_rd = {4'hA, 3'b000, conf_m};
    model(w);
    frame({16'h0, w}, 16, r);
    cyc(8);
    chk("miso_readback", {16'h0, r[15:0]}, {16'h0, exp_rd});
  endtask

  task automatic empty_frame();
    spi.ncs = 1'b0;
    cyc(4);
    spi.ncs = 1'b1;
    cyc(8);
  endtask

  initial begin
    spi.spck = 1'b0;
    spi.mosi = 1'b0;
    spi.ncs  = 1'b1;
    cyc(3);
    chk("reset_conf", {23'b0, conf_word}, 32'h1C0);
    chk("reset_trace", {31'b0, trace_enable}, 32'd0);
    chk("reset_miso", {31'b0, spi.miso}, 32'd0);
    chk("reset_strobe", {31'b0, cmd_strobe}, 32'd0);
    chk("reset_frame_err", {31'b0, frame_err}, 32'd0);
    chk("reset_err_cnt", {24'b0, err_cnt}, 32'd0);
    nreset = 1'b1;
    cyc(2);

    // first frame: exact commit latency after ncs rises
    model(16'h11C2);
    frame(32'h11C2, 16, rd);
    cyc(3);
    chk("latency_before", {23'b0, conf_word}, 32'h1C0);
    cyc(1);
    chk("latency_at", {23'b0, conf_word}, 32'h1C2);
    cyc(6);
    chk("miso_first", {16'h0, rd[15:0]}, 32'hA1C0);
    chk("trace_unchanged", {31'b0, trace_enable}, 32'd0);

    full(16'h2001);
    chk("trace_on", {31'b0, trace_enable}, 32'd1);
    full(16'h2000);
    chk("trace_off", {31'b0, trace_enable}, 32'd0);
    chk("conf_kept", {23'b0, conf_word}, 32'h1C2);

    frame(32'h0000_11C5 >> 1, 15, rd);
    cyc(8);
    frame(32'h0001_11C5, 17, rd);
    cyc(8);
    chk("bad_frame_err", {31'b0, frame_err}, 32'd1);
    chk("bad_err_cnt", {24'b0, err_cnt}, 32'd2);
    chk("bad_conf_kept", {23'b0, conf_word}, 32'h1C2);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_frame_err", {31'b0, frame_err}, 32'd0);
    chk("clr_err_cnt", {24'b0, err_cnt}, 32'd0);

    full(16'h10A5);
    chk("conf_0a5", {23'b0, conf_word}, 32'h0A5);
    full(16'h3000);
    chk("other_opcode_conf", {23'b0, conf_word}, 32'h0A5);

    // reset in the middle of a frame
    spi.ncs = 1'b0;
    cyc(4);
    send_bits(32'h10, 8, rd);
    nreset = 1'b0;
    cyc(2);
    chk("midreset_conf", {23'b0, conf_word}, 32'h1C0);
    spi.ncs  = 1'b1;
    spi.mosi = 1'b0;
    cyc(2);
    nreset = 1'b1;
    cyc(8);
    chk("midreset_state", {30'b0, dut.state_q}, {30'b0, ST_IDLE});
    chk("midreset_conf_after", {23'b0, conf_word}, 32'h1C0);
    conf_m  = 9'h1C0;
    trace_m = 1'b0;
    full(16'h1005);
    chk("conf_005", {23'b0, conf_word}, 32'h005);

    // saturate the error counter
    repeat (255) empty_frame();
    chk("err_cnt_255", {24'b0, err_cnt}, 32'd255);
    empty_frame();
    chk("err_cnt_sat", {24'b0, err_cnt}, 32'd255);
    chk("frame_err_sat", {31'b0, frame_err}, 32'd1);

    // clr_err lands on the commit cycle of a bad frame
    spi.ncs = 1'b0;
    cyc(4);
    spi.ncs = 1'b1;
    cyc(3);
    clr_err = 1'b1;
    cyc(1);
    clr_err = 1'b0;
    chk("clr_prio_cnt", {24'b0, err_cnt}, 32'd0);
    chk("clr_prio_flag", {31'b0, frame_err}, 32'd0);
    cyc(8);
    chk("clr_prio_hold", {24'b0, err_cnt}, 32'd0);

    cyc(10);
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
